// File: rtl/ro_window_counter.sv
// ro_window_counter
// -----------------
// Multi-channel windowed event counter for the ring-oscillator PUF
// measurement path. Each oscillator/mux output is synchronised to clk, and
// its rising edges (or its high cycles, in level mode) are counted over an
// exact window of WINDOW clock cycles. At the end of the window all channel
// counts are latched together and a one-cycle done pulse is raised.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      begin a measurement (sampled only in IDLE)
//   abort      cancel a measurement in progress (ARM or COUNT)
//   mode_level 0 = count rising edges, 1 = count high cycles (sampled at start)
//   ro_in      raw oscillator outputs, asynchronous to clk
//   busy       measurement in progress
//   done       one-cycle pulse, count_out/sat freshly updated
//   count_out  latched counts, channel i at [i*CNT_W +: CNT_W]
//   sat        latched per-channel saturation flags

module ro_window_counter #(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode_level,
  input  logic [NUM_CH-1:0]       ro_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       sat
);

  // The window counter only ever holds 0..WINDOW-1.
  localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT
  } state_t;

  state_t                  state;
  logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]       s;
  logic [NUM_CH-1:0]       hist;
  logic [NUM_CH-1:0]       evt;
  logic                    mode_q;
  logic [WIN_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        cnt     [NUM_CH];
  logic [CNT_W-1:0]        cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]       sat_int;
  logic [NUM_CH-1:0]       sat_nxt;
  logic [NUM_CH*CNT_W-1:0] cnt_flat_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  // Edge mode compares against the history flop; since hist always follows s,
  // the history taken during ARM keeps an already-high input from counting
  // as an edge in the first COUNT cycle.
  assign evt = mode_q ? s : (s & ~hist);

  // Input synchronisers and edge history run in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist <= '0;
    end else begin
      sync_q[0] <= ro_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist <= s;
    end
  end

  // Saturating next-count per channel; an event at max sets the sticky flag
  // instead of wrapping.
  always_comb begin
    cnt_flat_nxt = '0;
    sat_nxt      = sat_int;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (evt[i]) begin
        if (cnt[i] == CNT_MAX) sat_nxt[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end
      cnt_flat_nxt[i*CNT_W +: CNT_W] = cnt_nxt[i];
    end
  end

  // Control FSM with registered busy/done and the latched result registers.
  // The final-window event is folded into the latched result via cnt_nxt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count_out <= '0;
      sat       <= '0;
      mode_q    <= 1'b0;
      win_cnt   <= '0;
      sat_int   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ARM;
            busy   <= 1'b1;
            mode_q <= mode_level;
          end
        end
        ARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            sat_int <= '0;
            win_cnt <= WIN_LOAD;
            state   <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt     <= cnt_nxt;
            sat_int <= sat_nxt;
            if (win_cnt == '0) begin
              count_out <= cnt_flat_nxt;
              sat       <= sat_nxt;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              win_cnt <= win_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_window_counter.sv
// tb_ro_window_counter
// Directed bench for ro_window_counter. Two instances: dut_a (4 channels,
// 16-bit counters, 16-cycle window) and dut_b (4 channels, 4-bit counters,
// 32-cycle window) for saturation.
// dut_a channels: ch0 toggles every clk, ch1 held high, ch2/ch3 low.

module tb_ro_window_counter;

  logic        clk;
  logic        rst;
  logic        start_a, abort_a, mode_a;
  logic        start_b, abort_b, mode_b;
  logic        tog = 1'b0;
  logic [2:0]  ro_a_hi;
  logic [3:0]  ro_a;
  logic [3:0]  ro_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [63:0] count_a;
  logic [15:0] count_b;
  logic [3:0]  sat_a, sat_b;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int dk, bn, t1, t2;
  logic seen_done;

  assign ro_a = {ro_a_hi, tog};

  ro_window_counter #(.NUM_CH(4), .CNT_W(16), .WINDOW(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode_level(mode_a),
    .ro_in(ro_a), .busy(busy_a), .done(done_a), .count_out(count_a), .sat(sat_a)
  );

  ro_window_counter #(.NUM_CH(4), .CNT_W(4), .WINDOW(32), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode_level(mode_b),
    .ro_in(ro_b), .busy(busy_b), .done(done_b), .count_out(count_b), .sat(sat_b)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter for measuring done-pulse spacing
  always @(posedge clk) cyc <= cyc + 1;

  // ch0 of dut_a toggles every clock, giving a period-2 square wave
  always @(negedge clk) tog = ~tog;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue a start on one DUT and follow it until done (bounded). Samples are
  // taken at negedges; k=0 is the sample right after the edge that took start.
  // pulse_at >= 0 drives an extra start pulse while busy.
  task automatic apply_stimulus(input bit use_b, input bit lvl, input int pulse_at,
                                output int done_k, output int busy_n);
    done_k = -1;
    busy_n = 0;
    if (use_b) begin start_b = 1'b1; mode_b = lvl; end
    else       begin start_a = 1'b1; mode_a = lvl; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    abort_a = 1'b0;
    mode_a  = ~lvl;
    mode_b  = ~lvl;
    for (int k = 0; k < 200; k++) begin
      if (use_b ? busy_b : busy_a) busy_n++;
      if (use_b ? done_b : done_a) begin
        done_k = k;
        break;
      end
      if (use_b) start_b = (k == pulse_at);
      else       start_a = (k == pulse_at);
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 1'b0;
    ro_a_hi = 3'b001;
    ro_b    = 4'b1000;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 64'(busy_a), 64'd0);
    check_output("reset_done", 64'(done_a), 64'd0);
    check_output("reset_count", count_a, 64'd0);
    check_output("reset_sat", 64'(sat_a), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] edge-mode run");
    apply_stimulus(1'b0, 1'b0, -1, dk, bn);
    check_output("edge_done_lat", 64'(dk), 64'd17);
    check_output("edge_busy_len", 64'(bn), 64'd17);
    check_output("edge_count", count_a, 64'h0000_0000_0000_0008);
    check_output("edge_sat", 64'(sat_a), 64'd0);
    @(negedge clk);
    check_output("done_one_cycle", 64'(done_a), 64'd0);

    $display("[TB] level-mode run");
    apply_stimulus(1'b0, 1'b1, -1, dk, bn);
    check_output("level_done_lat", 64'(dk), 64'd17);
    check_output("level_count", count_a, 64'h0000_0000_0010_0008);
    @(negedge clk);

    $display("[TB] start during busy, back-to-back");
    apply_stimulus(1'b0, 1'b0, 5, dk, bn);
    t1 = cyc;
    check_output("busy_start_lat", 64'(dk), 64'd17);
    check_output("busy_start_len", 64'(bn), 64'd17);
    apply_stimulus(1'b0, 1'b0, -1, dk, bn);
    t2 = cyc;
    check_output("b2b_done_lat", 64'(dk), 64'd17);
    check_output("b2b_spacing", 64'(t2 - t1), 64'd18);
    check_output("b2b_count", count_a, 64'h0000_0000_0000_0008);
    @(negedge clk);

    $display("[TB] abort mid-count");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check_output("abort_busy", 64'(busy_a), 64'd0);
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    check_output("abort_no_done", 64'(seen_done), 64'd0);
    check_output("abort_count_kept", count_a, 64'h0000_0000_0000_0008);

    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check_output("idle_abort_busy", 64'(busy_a), 64'd0);

    $display("[TB] start and abort together in IDLE");
    abort_a = 1'b1;
    apply_stimulus(1'b0, 1'b1, -1, dk, bn);
    check_output("start_wins_lat", 64'(dk), 64'd17);
    check_output("start_wins_count", count_a, 64'h0000_0000_0010_0008);
    @(negedge clk);

    $display("[TB] reset mid-count");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst_busy", 64'(busy_a), 64'd0);
    check_output("midrst_done", 64'(done_a), 64'd0);
    check_output("midrst_count", count_a, 64'd0);
    check_output("midrst_sat", 64'(sat_a), 64'd0);
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    check_output("midrst_no_done", 64'(seen_done), 64'd0);

    $display("[TB] saturation on narrow counters");
    apply_stimulus(1'b1, 1'b1, -1, dk, bn);
    check_output("sat_done_lat", 64'(dk), 64'd33);
    check_output("sat_busy_len", 64'(bn), 64'd33);
    check_output("sat_count", 64'(count_b), 64'h0000_0000_0000_F000);
    check_output("sat_flags", 64'(sat_b), 64'h8);
    ro_b = 4'b0000;
    repeat (5) @(negedge clk);
    apply_stimulus(1'b1, 1'b1, -1, dk, bn);
    check_output("unsat_count", 64'(count_b), 64'd0);
    check_output("unsat_flags", 64'(sat_b), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ro_window_counter.md
Name: ro_window_counter

Overview:
Multi-channel, windowed event counter for the ring-oscillator PUF measurement path. It is the parametrised successor to the single free-running counter. Each of NUM_CH oscillator/mux outputs is synchronised and its rising edges (or high samples) are counted over an exact window of WINDOW clock cycles. All channel counts are then latched together and a done pulse is raised for the downstream comparator/response logic.

Parameters:
NUM_CH, 8, number of independent counting channels
CNT_W, 16, width of each channel counter
WINDOW, 1024, measurement window length in clk cycles (>=1)
SYNC_STAGES, 2, flip-flop stages in each channel's input synchroniser (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  begin a measurement; sampled only in IDLE
abort  input  1  cancel measurement in progress
mode_level  input  1  0 = count rising edges, 1 = count clock cycles with the input high; sampled at start
ro_in  input  NUM_CH  raw oscillator/mux outputs, asynchronous to clk
busy  output  1  measurement in progress (ARM or COUNT)
done  output  1  one-cycle pulse: count_out/sat valid and updated
count_out  output  NUM_CH*CNT_W  latched counts; channel i occupies bits [i*CNT_W +: CNT_W]
sat  output  NUM_CH  latched per-channel saturation flags

Behaviour:
- Reset (synchronous, checked on posedge clk) takes precedence over everything:
  - state=IDLE; busy=0, done=0, count_out=0, sat=0.
  - Internal counters, window counter and synchroniser flops are cleared.
- Synchroniser: each ro_in bit passes through SYNC_STAGES flops, giving s.
  - One extra history flop h gives edge = s & ~h.
  - level = s.
  - Synchronisers run in every state.
- FSM states IDLE, ARM, COUNT:
  - IDLE: busy=0. If start=1 at a clock edge, go to ARM and latch mode_level.
  - ARM (exactly 1 cycle): clear all channel counters and sat bits. Force h<=s so a level already high is not counted as an edge. Load the window counter with WINDOW-1. Go to COUNT.
  - COUNT (exactly WINDOW cycles): on each edge, each channel increments if its event is true (edge or level, per latched mode). Then the window counter decrements.
  - When the window counter = 0, the final event is still counted. At the same edge: count_out/sat <= final values (including that event), done<=1 for one cycle, state->IDLE.
- Latency: with start sampled at edge E0, done is high during the cycle after edge E0+WINDOW+1.
  - busy is high for WINDOW+1 cycles.
  - A new start is accepted in the same cycle done is high (state is IDLE).
- Arithmetic: per-channel counters saturate at 2^CNT_W-1 and never wrap.
  - sat[i] is set when an event occurs while channel i is already at max.
  - sat[i] stays set until the next ARM.
- start while busy: ignored.
- abort (COUNT or ARM): next state IDLE, busy=0, no done pulse, count_out/sat keep their previous values. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start wins.
- count_out and sat change only at reset or at the done edge. They are stable at all other times.
- mode_level changes during busy have no effect.

Test Plan:
- WINDOW=16, edge mode; ch0 toggles every clk (period 2, first rise after ARM); ch1 held 1; ch2 held 0 -> done at E0+17; ch0=8, ch1=0, ch2=0, sat=0; busy high 17 cycles.
- Same stimulus, mode_level=1 -> ch0=8, ch1=16, ch2=0.
- CNT_W=4, WINDOW=32, level mode, ch3 held 1 -> ch3=15, sat[3]=1. Next run with ch3=0 -> ch3=0, sat[3]=0.
- Start pulses during busy, plus a start on the done cycle -> extra busy pulses ignored. Back-to-back runs have done pulses exactly 18 cycles apart (WINDOW=16).
- abort 5 cycles into COUNT after a prior run left ch0=8 -> busy drops next cycle, no done, count_out still 8. A fresh start completes normally.
- rst asserted mid-COUNT for 1 cycle -> next cycle busy=0, done=0, count_out=0, sat=0. No done appears afterwards without a new start.
